prescaler_burst: RTL and testbench
==================================

// Module: prescaler_burst
// PURPOSE
//  Parametrised successor of the 8-bit prescaler. Divides i_sysclk into o_sclk (50% duty) with
//  one-cycle rise/fall strobes, selected by a loadable scale value. Adds a burst mode that emits
//  exactly N o_sclk periods per i_start, plus busy/done status. Feeds the 16-bit counter and the
//  serial peripherals as their timebase.
// PARAMETERS
//  DIV_W      8   width of the scale value; half period = scale+1 sysclk cycles
//  BURST_W    8   width of the burst length
//  RST_SCALE  0   active/shadow scale value after reset
// PORTS
//  i_sysclk     in   1        system clock; all logic on rising edge
//  i_sysrst_n   in   1        asynchronous, active-low reset
//  i_module_en  in   1        block enable; low aborts any activity
//  i_mode       in   1        0 = continuous, 1 = burst; sampled when leaving IDLE
//  i_start      in   1        burst start strobe; ignored unless IDLE and i_mode=1
//  i_burst_len  in   BURST_W  number of o_sclk periods per burst; sampled on accepted i_start
//  i_ld         in   1        load strobe for i_ld_data
//  i_ld_data    in   DIV_W    new scale value
//  o_sclk       out  1        divided clock, registered
//  o_sclk_rise  out  1        1-cycle pulse in the cycle o_sclk goes 0->1
//  o_sclk_fall  out  1        1-cycle pulse in the cycle o_sclk goes 1->0
//  o_busy       out  1        high in RUN or BURST
//  o_done       out  1        1-cycle pulse at burst completion
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, cnt 0, active and shadow scale = RST_SCALE, remaining 0.
//  - States: IDLE, RUN, BURST. All outputs are registered.
//    IDLE->RUN   : i_module_en & i_mode=0.
//    IDLE->BURST : i_module_en & i_mode=1 & i_start & i_burst_len!=0; remaining <= i_burst_len.
//    IDLE, i_start with i_burst_len==0: stay IDLE; o_done pulses the next cycle.
//    RUN->IDLE   : i_mode=1 observed; the current period completes, exit on the next fall.
//    BURST->IDLE : on the fall that brings remaining to 0; o_done is coincident with that fall.
//    Any state, i_module_en=0: next cycle IDLE, o_sclk=0, cnt=0, no fall strobe, no o_done.
//  - Entering RUN/BURST: o_sclk=0, cnt=0. cnt increments each cycle; at cnt==scale, o_sclk
//    toggles, cnt<=0, and the matching strobe asserts. First rise occurs scale+1 cycles after entry.
//    Period = 2*(scale+1) cycles. scale=0 gives o_sclk = sysclk/2 with a strobe every cycle.
//  - i_start while busy is ignored. remaining decrements on each o_sclk_fall in BURST.
//  - Reset asserted mid-operation clears everything asynchronously; no strobes are emitted.
// CONFIGURATION
//  PRESCALER_SHADOW_EN defined: i_ld writes the shadow register. Shadow->active only at a fall
//   boundary (or in IDLE), so loads are glitch-free. i_ld in the same cycle as a fall boundary
//   bypasses, and the new value governs the next half period.
//  Not defined: i_ld writes the active scale directly and clears cnt. The o_sclk level is held,
//   and the current half period restarts with the new length.
// STRUCTURE
//  - prescaler_pkg: state encodings (ST_IDLE/ST_RUN/ST_BURST) and mode constants
//    (MODE_CONT=0, MODE_BURST=1).
//  - One sub-module, prescaler_halfcnt: DIV_W counter with a terminal-count output and a sync
//    clear. The top level holds the FSM, the scale registers and the burst counter.
// TESTING
//  1 reset low 60ns, en=1, mode=0, scale=0 -> o_sclk toggles every cycle; rise/fall alternate.
//  2 continuous, ld 7 -> after the boundary (shadow) o_sclk period=16 cycles, rise every 16, 8 high.
//  3 mode=1, burst_len=3, scale=1, start -> exactly 3 rises and 3 falls.
//    o_done is coincident with the 3rd fall; o_busy is high for 12 cycles.
//  4 burst_len=0 start -> no sclk activity, o_done 1 cycle later, o_busy stays 0.
//  5 en dropped mid-burst while o_sclk=1 -> next cycle o_sclk=0, no fall strobe, no o_done.
//  6 ld in the same cycle as a fall boundary (shadow build) -> next half period uses the new value.
//    Non-shadow build -> cnt restarts and the level is held.

Source files
------------

// File: rtl/prescaler_pkg.sv
// ============================================================================
// prescaler_pkg : state and mode encodings shared by the prescaler_burst block
// Revision 1.0
// ============================================================================
`default_nettype none

package prescaler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BURST = 2'd2
    } state_e;

    localparam logic MODE_CONT  = 1'b0;
    localparam logic MODE_BURST = 1'b1;

endpackage

`default_nettype wire

// File: rtl/prescaler_halfcnt.sv
// ============================================================================
// prescaler_halfcnt : half-period counter with terminal count and sync clear
// Revision 1.0
// ============================================================================
`default_nettype none

module prescaler_halfcnt #(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] limit_i,
    output logic             tc_o
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    assign tc_o = (cnt_q == limit_i);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || (en_i && tc_o)) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/prescaler_burst.sv
// ============================================================================
// prescaler_burst : clock prescaler with continuous and N-period burst modes.
// Define PRESCALER_SHADOW_EN for shadowed, fall-aligned scale loads.
// Revision 1.0
// ============================================================================
`default_nettype none

module prescaler_burst
    import prescaler_pkg::*;
#(
    parameter int               DIV_W     = 8,
    parameter int               BURST_W   = 8,
    parameter logic [DIV_W-1:0] RST_SCALE = '0
) (
    input  logic               i_sysclk,
    input  logic               i_sysrst_n,
    input  logic               i_module_en,
    input  logic               i_mode,
    input  logic               i_start,
    input  logic [BURST_W-1:0] i_burst_len,
    input  logic               i_ld,
    input  logic [DIV_W-1:0]   i_ld_data,
    output logic               o_sclk,
    output logic               o_sclk_rise,
    output logic               o_sclk_fall,
    output logic               o_busy,
    output logic               o_done
);

    state_e             state_q, state_d;
    logic               sclk_q, sclk_d;
    logic               rise_q, rise_d;
    logic               fall_q, fall_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               stop_q, stop_d;
    logic [BURST_W-1:0] remaining_q, remaining_d;
    logic [DIV_W-1:0]   scale_q, scale_d;
    logic               tc;
    logic               cnt_clr;
    logic               cnt_en;
    logic               ld_restart;

    prescaler_halfcnt #(.DIV_W(DIV_W)) u_halfcnt (
        .clk_i   (i_sysclk),
        .rst_n_i (i_sysrst_n),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .limit_i (scale_q),
        .tc_o    (tc)
    );

`ifdef PRESCALER_SHADOW_EN
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             fall_bnd;

    assign ld_restart = 1'b0;
    assign fall_bnd   = i_module_en && (state_q != ST_IDLE) && tc && sclk_q;

    // A load coinciding with a fall boundary bypasses the shadow so it governs the next half.
    always_comb begin
        shadow_d = i_ld ? i_ld_data : shadow_q;
        scale_d  = scale_q;
        if ((state_q == ST_IDLE) || fall_bnd) begin
            scale_d = shadow_d;
        end
    end

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            shadow_q <= RST_SCALE;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`else
    assign ld_restart = i_ld;

    always_comb begin
        scale_d = i_ld ? i_ld_data : scale_q;
    end
`endif

    always_comb begin
        state_d     = state_q;
        sclk_d      = sclk_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        done_d      = 1'b0;
        stop_d      = stop_q;
        remaining_d = remaining_q;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        if (!i_module_en) begin
            state_d     = ST_IDLE;
            sclk_d      = 1'b0;
            stop_d      = 1'b0;
            remaining_d = '0;
            cnt_clr     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_clr = 1'b1;
                    stop_d  = 1'b0;
                    sclk_d  = 1'b0;
                    if (i_mode == MODE_CONT) begin
                        state_d = ST_RUN;
                    end else if (i_start) begin
                        if (i_burst_len != '0) begin
                            state_d     = ST_BURST;
                            remaining_d = i_burst_len;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                ST_RUN, ST_BURST: begin
                    // A stop request in RUN is remembered so the period still completes.
                    if ((state_q == ST_RUN) && (i_mode == MODE_BURST)) begin
                        stop_d = 1'b1;
                    end
                    if (ld_restart) begin
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_en = 1'b1;
                        if (tc) begin
                            sclk_d = ~sclk_q;
                            rise_d = ~sclk_q;
                            fall_d = sclk_q;
                            if (sclk_q) begin
                                if (state_q == ST_RUN) begin
                                    if (stop_d) begin
                                        state_d = ST_IDLE;
                                        stop_d  = 1'b0;
                                    end
                                end else begin
                                    remaining_d = remaining_q - 1'b1;
                                    if (remaining_q == {{(BURST_W-1){1'b0}}, 1'b1}) begin
                                        state_d = ST_IDLE;
                                        done_d  = 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    sclk_d  = 1'b0;
                    cnt_clr = 1'b1;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge i_sysclk or negedge i_sysrst_n) begin
        if (!i_sysrst_n) begin
            state_q     <= ST_IDLE;
            sclk_q      <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            stop_q      <= 1'b0;
            remaining_q <= '0;
            scale_q     <= RST_SCALE;
        end else begin
            state_q     <= state_d;
            sclk_q      <= sclk_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            stop_q      <= stop_d;
            remaining_q <= remaining_d;
            scale_q     <= scale_d;
        end
    end

    assign o_sclk      = sclk_q;
    assign o_sclk_rise = rise_q;
    assign o_sclk_fall = fall_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_prescaler_burst.sv
// ============================================================================
// tb_prescaler_burst : self-checking bench for prescaler_burst
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_prescaler_burst;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, mode, start, ld;
    logic [7:0] blen, ldd;
    logic       sclk, rise, fall, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    prescaler_burst #(.DIV_W(8), .BURST_W(8), .RST_SCALE(8'd0)) dut (
        .i_sysclk    (clk),
        .i_sysrst_n  (rst_n),
        .i_module_en (en),
        .i_mode      (mode),
        .i_start     (start),
        .i_burst_len (blen),
        .i_ld        (ld),
        .i_ld_data   (ldd),
        .o_sclk      (sclk),
        .o_sclk_rise (rise),
        .o_sclk_fall (fall),
        .o_busy      (busy),
        .o_done      (done)
    );

    // Reference: 0 idle, 1 continuous, 2 burst; m_el counts cycles spent in the current half.
    int m_state, m_el, m_active, m_shadow, m_left;
    bit m_lvl, m_stop, m_rise, m_fall, m_done, m_busy;

    typedef struct {
        int scale;
        int blen;
        int exp_rise;
        int exp_fall;
        int exp_busy;
        int exp_done;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int  nact;
        bit  last, restart;
        m_rise  = 0;
        m_fall  = 0;
        m_done  = 0;
        last    = (m_state != 0) && (m_el == m_active);
`ifdef PRESCALER_SHADOW_EN
        restart = 0;
        begin
            int nsh;
            nsh  = ld ? int'(ldd) : m_shadow;
            nact = ((m_state == 0) || (en && last && m_lvl)) ? nsh : m_active;
            m_shadow = nsh;
        end
`else
        restart = ld;
        nact    = ld ? int'(ldd) : m_active;
`endif
        if (!en) begin
            m_state = 0; m_lvl = 0; m_el = 0; m_left = 0; m_stop = 0;
        end else if (m_state == 0) begin
            m_el = 0; m_stop = 0;
            if (!mode) m_state = 1;
            else if (start) begin
                if (blen == 0) m_done = 1;
                else begin m_state = 2; m_left = blen; end
            end
        end else begin
            if (m_state == 1 && mode) m_stop = 1;
            if (restart) m_el = 0;
            else if (last) begin
                m_el  = 0;
                m_lvl = !m_lvl;
                if (m_lvl) m_rise = 1;
                else begin
                    m_fall = 1;
                    if (m_state == 1 && m_stop) begin m_state = 0; m_stop = 0; end
                    else if (m_state == 2) begin
                        m_left--;
                        if (m_left == 0) begin m_state = 0; m_done = 1; end
                    end
                end
            end else m_el++;
        end
        m_active = nact;
        m_busy   = (m_state != 0);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("model", {27'd0, sclk, rise, fall, busy, done},
            {27'd0, m_lvl, m_rise, m_fall, m_busy, m_done});
    endtask

    task automatic wait_idle();
        mode = 1'b1;
        for (int i = 0; i < 300 && busy; i++) step();
        chk("reach_idle", busy, 0);
    endtask

    task automatic set_scale(input int v);
        ld  = 1'b1;
        ldd = 8'(v);
        step();
        ld  = 1'b0;
    endtask

    initial begin
        int  rc, fc, bc, dc, per, hi;
        bit  got, dfall;
        logic s1_sclk, s1_fall;

        tbl[0] = '{1, 3, 3, 3, 12, 1};
        tbl[1] = '{0, 1, 1, 1,  2, 1};
        tbl[2] = '{2, 2, 2, 2, 12, 1};
        tbl[3] = '{0, 5, 5, 5, 10, 1};
        tbl[4] = '{3, 1, 1, 1,  8, 1};

        rst_n = 1'b0; en = 0; mode = 0; start = 0; ld = 0; blen = 0; ldd = 0;
        m_state = 0; m_el = 0; m_active = 0; m_shadow = 0; m_left = 0;
        m_lvl = 0; m_stop = 0; m_rise = 0; m_fall = 0; m_done = 0; m_busy = 0;
        #50;
        chk("reset_state", {27'd0, sclk, rise, fall, busy, done}, 0);
        #10 rst_n = 1'b1;

        // Continuous at scale 0: toggle every cycle.
        en = 1'b1; mode = 1'b0;
        step();
        chk("t1_entry", {29'd0, sclk, busy, rise}, 3'b010);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("t1_toggle", {29'd0, sclk, rise, fall},
                (k % 2 == 1) ? 32'b110 : 32'b001);
        end

        // Load scale 7 while running: period 16, high 8.
        ld = 1'b1; ldd = 8'd7; step(); ld = 1'b0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin step(); if (rise) got = 1; end
        chk("t2_rise_found", got, 1);
        got = 0; per = 0; hi = 1;
        for (int i = 0; i < 40 && !got; i++) begin
            step(); per++;
            if (rise) got = 1; else if (sclk) hi++;
        end
        chk("t2_period", per, 16);
        chk("t2_high", hi, 8);

        // Burst vectors.
        for (int v = 0; v < 5; v++) begin
            wait_idle();
            set_scale(tbl[v].scale);
            start = 1'b1; blen = 8'(tbl[v].blen); step(); start = 1'b0;
            rc = 0; fc = 0; bc = 0; dc = 0; dfall = 0;
            for (int c = 0; c < tbl[v].exp_busy + 8; c++) begin
                rc += rise; fc += fall; bc += busy; dc += done;
                if (done) dfall = fall;
                step();
            end
            chk("burst_rises", rc, tbl[v].exp_rise);
            chk("burst_falls", fc, tbl[v].exp_fall);
            chk("burst_busy",  bc, tbl[v].exp_busy);
            chk("burst_done",  dc, tbl[v].exp_done);
            chk("burst_done_on_fall", dfall, 1);
        end

        // Zero-length burst: only a done pulse.
        wait_idle();
        start = 1'b1; blen = 8'd0; step(); start = 1'b0;
        chk("t4_done", {30'd0, done, busy}, 2'b10);
        bc = 0; rc = 0; dc = 0;
        for (int c = 0; c < 6; c++) begin
            step(); bc += busy; rc += rise + fall + sclk; dc += done;
        end
        chk("t4_quiet", {bc[7:0], rc[7:0], dc[7:0]}, 0);

        // Abort mid-burst while sclk is high.
        set_scale(2);
        start = 1'b1; blen = 8'd4; step(); start = 1'b0;
        for (int i = 0; i < 20 && !sclk; i++) step();
        chk("t5_setup_high", sclk, 1);
        en = 1'b0; step();
        chk("t5_abort", {28'd0, sclk, fall, done, busy}, 0);
        dc = 0;
        for (int c = 0; c < 4; c++) begin step(); dc += done + fall; end
        chk("t5_no_done", dc, 0);
        en = 1'b1;

        // Load landing exactly on a fall boundary.
        wait_idle();
        set_scale(3);
        mode = 1'b0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin step(); if (rise) got = 1; end
        chk("t6_rise_found", got, 1);
        step(); step(); step();
        ld = 1'b1; ldd = 8'd1; step(); ld = 1'b0;
        s1_sclk = sclk; s1_fall = fall;
        step(); step();
`ifdef PRESCALER_SHADOW_EN
        chk("t6_boundary", {30'd0, s1_sclk, s1_fall}, 2'b01);
        chk("t6_next_half", {30'd0, rise, fall}, 2'b10);
`else
        chk("t6_boundary", {30'd0, s1_sclk, s1_fall}, 2'b10);
        chk("t6_next_half", {30'd0, rise, fall}, 2'b01);
`endif

        // Randomised traffic against the reference.
        for (int c = 0; c < 1500; c++) begin
            en    = ($urandom_range(0, 99) < 97);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            start = ($urandom_range(0, 9) == 0);
            blen  = 8'($urandom_range(0, 4));
            ld    = ($urandom_range(0, 29) == 0);
            ldd   = 8'($urandom_range(0, 3));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
